// File: rtl/mcb_sched_pkg.sv
// Shared types and constants for the MCB port-0 frame scheduler.
//   state_t   : scheduler FSM states
//   grant_t   : which requester owns the port for the current burst
//   CMD_WRITE / CMD_READ : MCB p0_cmd_instr encodings
package mcb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_FILL  = 3'd1,
    WR_CMD   = 3'd2,
    RD_CMD   = 3'd3,
    RD_DRAIN = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mcb_frame_sched.sv
// MCB port-0 scheduler for the frame-buffer path. Shares one MCB port between
// the capture path (input FIFO -> DDR2 writes) and the host readout path
// (DDR2 reads -> output FIFO) using fixed-length bursts, round-robin between
// the two sides, with reads never overtaking written data.
//
// Ports:
//   clk, reset          : MCB user clock, synchronous active-high reset
//   calib_done          : no new grants while low
//   frame_start         : pulse, rearms pointers (latched until IDLE)
//   ib_count/ib_data/ib_re            : input FIFO (FWFT) side
//   ob_count/ob_we/ob_data            : output FIFO side
//   p0_cmd_*            : MCB command channel
//   p0_wr_*             : MCB write-data channel
//   p0_rd_*             : MCB read-data channel
//   frame_written       : pulse after the last write burst of a frame is accepted
//   frame_read          : pulse after the last word of a frame reaches the output FIFO
//   busy                : FSM not in IDLE
//
// Build option: define PINGPONG_EN for two alternating frame buffers
// (BASE_ADDR and BASE_ADDR+BANK_STRIDE) with per-bank full flags.
module mcb_frame_sched
  import mcb_sched_pkg::*;
#(
  parameter int          BURST_LEN   = 32,
  parameter int          FRAME_WORDS = 1310720,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter logic [29:0] BANK_STRIDE = 30'h0080_0000,
  parameter int          OB_DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        frame_start,
  input  logic [23:0] ib_count,
  input  logic [31:0] ib_data,
  output logic        ib_re,
  input  logic [10:0] ob_count,
  output logic        ob_we,
  output logic [31:0] ob_data,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  input  logic        p0_cmd_full,
  output logic        p0_wr_en,
  output logic [31:0] p0_wr_data,
  output logic [3:0]  p0_wr_mask,
  input  logic        p0_wr_full,
  output logic        p0_rd_en,
  input  logic [31:0] p0_rd_data,
  input  logic        p0_rd_empty,
  output logic        frame_written,
  output logic        frame_read,
  output logic        busy
);

  // Pointers count 32-bit words; 25 bits covers any frame a 24-bit FIFO
  // count can describe.
  localparam int PTR_W = 25;
  localparam int CNT_W = 7;
  localparam logic [PTR_W-1:0] FRAME_PTR = PTR_W'(FRAME_WORDS);
  localparam logic [PTR_W-1:0] BURST_PTR = PTR_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  function automatic logic [29:0] burst_addr(input logic bank,
                                             input logic [PTR_W-1:0] ptr);
    return BASE_ADDR + (bank ? BANK_STRIDE : 30'h0) + 30'({ptr, 2'b00});
  endfunction

  state_t           state;
  grant_t           last_grant;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] xfer_cnt;
  logic             fs_pend;
  logic             cmd_en_q;
  logic [2:0]       cmd_instr_q;
  logic [29:0]      cmd_addr_q;
  logic             frame_written_q;
  logic             frame_read_q;

  logic [PTR_W-1:0] trail;
  logic             ob_room;
  logic             rd_data_ok;
  logic             wr_elig;
  logic             rd_elig;
  logic             wr_last;
  logic             rd_last;
  logic [29:0]      wr_addr;
  logic [29:0]      rd_addr;

  assign trail   = wr_ptr - rd_ptr;
  // Unsigned form of (OB_DEPTH - ob_count) >= BURST_LEN that cannot wrap.
  assign ob_room = ({21'd0, ob_count} + 32'(BURST_LEN)) <= 32'(OB_DEPTH);
  assign wr_last = (wr_ptr + BURST_PTR) == FRAME_PTR;
  assign rd_last = (rd_ptr + BURST_PTR) == FRAME_PTR;

`ifdef PINGPONG_EN
  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] bank_full;
  logic       bank_adv;

  // A full bank is readable regardless of where the writer is; otherwise the
  // reader may only trail the writer inside the same bank.
  assign rd_data_ok = bank_full[rd_bank] |
                      ((rd_bank == wr_bank) & (trail >= BURST_PTR));
  // Writer parked at the end of a full bank moves on once the other bank
  // has been drained by the reader.
  assign bank_adv   = (wr_ptr == FRAME_PTR) & bank_full[wr_bank] & ~bank_full[~wr_bank];
  assign wr_addr    = burst_addr(wr_bank, wr_ptr);
  assign rd_addr    = burst_addr(rd_bank, rd_ptr);
`else
  assign rd_data_ok = trail >= BURST_PTR;
  assign wr_addr    = burst_addr(1'b0, wr_ptr);
  assign rd_addr    = burst_addr(1'b0, rd_ptr);
`endif

  assign wr_elig = calib_done & (wr_ptr < FRAME_PTR) & (ib_count >= 24'(BURST_LEN));
  assign rd_elig = calib_done & (rd_ptr < FRAME_PTR) & rd_data_ok & ob_room;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= GRANT_READ;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      xfer_cnt        <= '0;
      fs_pend         <= 1'b0;
      cmd_en_q        <= 1'b0;
      cmd_instr_q     <= CMD_WRITE;
      cmd_addr_q      <= '0;
      frame_written_q <= 1'b0;
      frame_read_q    <= 1'b0;
`ifdef PINGPONG_EN
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      bank_full       <= 2'b00;
`endif
    end else begin
      frame_written_q <= 1'b0;
      frame_read_q    <= 1'b0;
      if (frame_start) fs_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (fs_pend) begin
            // Rearm costs one IDLE cycle; a pulse arriving now is absorbed.
            fs_pend <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
`ifdef PINGPONG_EN
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
          end else if (bank_adv) begin
            wr_bank <= ~wr_bank;
            wr_ptr  <= '0;
`endif
          end else if (wr_elig && (!rd_elig || last_grant == GRANT_READ)) begin
            state      <= WR_FILL;
            last_grant <= GRANT_WRITE;
            xfer_cnt   <= '0;
          end else if (rd_elig) begin
            state       <= RD_CMD;
            last_grant  <= GRANT_READ;
            cmd_en_q    <= 1'b1;
            cmd_instr_q <= CMD_READ;
            cmd_addr_q  <= rd_addr;
          end
        end

        WR_FILL: begin
          if (!p0_wr_full) begin
            if (xfer_cnt == LAST_BEAT) begin
              xfer_cnt    <= '0;
              state       <= WR_CMD;
              cmd_en_q    <= 1'b1;
              cmd_instr_q <= CMD_WRITE;
              cmd_addr_q  <= wr_addr;
            end else begin
              xfer_cnt <= xfer_cnt + 1'b1;
            end
          end
        end

        WR_CMD: begin
          if (!p0_cmd_full) begin
            cmd_en_q <= 1'b0;
            state    <= IDLE;
            wr_ptr   <= wr_ptr + BURST_PTR;
            if (wr_last) begin
              frame_written_q <= 1'b1;
`ifdef PINGPONG_EN
              bank_full[wr_bank] <= 1'b1;
              if (!bank_full[~wr_bank]) begin
                wr_bank <= ~wr_bank;
                wr_ptr  <= '0;
              end
`endif
            end
          end
        end

        RD_CMD: begin
          if (!p0_cmd_full) begin
            cmd_en_q <= 1'b0;
            state    <= RD_DRAIN;
            xfer_cnt <= '0;
          end
        end

        RD_DRAIN: begin
          // Output FIFO space was reserved at grant time.
          if (!p0_rd_empty) begin
            if (xfer_cnt == LAST_BEAT) begin
              xfer_cnt <= '0;
              state    <= IDLE;
              rd_ptr   <= rd_ptr + BURST_PTR;
              if (rd_last) begin
                frame_read_q <= 1'b1;
`ifdef PINGPONG_EN
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
                rd_ptr             <= '0;
`endif
              end
            end else begin
              xfer_cnt <= xfer_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign ib_re            = (state == WR_FILL) & ~p0_wr_full;
  assign p0_wr_en         = ib_re;
  assign p0_wr_data       = ib_data;
  assign p0_wr_mask       = 4'b0000;
  assign p0_rd_en         = (state == RD_DRAIN) & ~p0_rd_empty;
  assign ob_we            = p0_rd_en;
  assign ob_data          = p0_rd_data;
  assign p0_cmd_en        = cmd_en_q;
  assign p0_cmd_instr     = cmd_instr_q;
  assign p0_cmd_bl        = 6'(BURST_LEN - 1);
  assign p0_cmd_byte_addr = cmd_addr_q;
  assign frame_written    = frame_written_q;
  assign frame_read       = frame_read_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_mcb_frame_sched.sv
// Bench for mcb_frame_sched: behavioural MCB port + input FIFO model,
// command / output-data scoreboard, directed frame sequences.
module tb_mcb_frame_sched;
  import mcb_sched_pkg::*;

  localparam int          BL     = 32;
  localparam int          FW     = 64;
  localparam logic [29:0] STRIDE = 30'h0080_0000;
  localparam logic [31:0] PIX0   = 32'hA500_0000;

  logic        clk = 1'b0;
  logic        reset, calib_done, frame_start;
  logic [23:0] ib_count;
  logic [31:0] ib_data;
  logic        ib_re;
  logic [10:0] ob_count;
  logic        ob_we;
  logic [31:0] ob_data;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_full;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_empty;
  logic        frame_written, frame_read, busy;

  mcb_frame_sched #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .BASE_ADDR(30'h0),
    .BANK_STRIDE(STRIDE), .OB_DEPTH(1024)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .frame_start(frame_start),
    .ib_count(ib_count), .ib_data(ib_data), .ib_re(ib_re),
    .ob_count(ob_count), .ob_we(ob_we), .ob_data(ob_data),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
    .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
    .p0_wr_full(p0_wr_full), .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
    .p0_rd_empty(p0_rd_empty), .frame_written(frame_written),
    .frame_read(frame_read), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [2:0]  instr;
    logic [29:0] addr;
    int          hold;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_ob[$];

  function automatic void push_cmd(input logic [2:0] instr, input logic [29:0] addr,
                                   input int hold);
    cmd_t c;
    c.instr = instr;
    c.addr  = addr;
    c.hold  = hold;
    exp_cmd.push_back(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- MCB port + input FIFO model ----------------
  logic [31:0] mem [int];
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  int          ib_idx = 0;

  initial begin
    bit          ipop, wpush, cacc, rpop;
    logic [31:0] wdata;
    logic [2:0]  cinstr;
    logic [29:0] caddr;
    ib_data     = PIX0;
    p0_rd_data  = '0;
    p0_rd_empty = 1'b1;
    p0_wr_full  = 1'b0;
    forever begin
      @(negedge clk);
      ipop   = ib_re;
      wpush  = p0_wr_en && !p0_wr_full;
      wdata  = p0_wr_data;
      cacc   = p0_cmd_en && !p0_cmd_full;
      cinstr = p0_cmd_instr;
      caddr  = p0_cmd_byte_addr;
      rpop   = p0_rd_en && !p0_rd_empty;
      @(posedge clk);
      #2;
      if (ipop) begin
        exp_ob.push_back(ib_data);
        ib_idx++;
      end
      if (wpush) wq.push_back(wdata);
      if (rpop && rq.size() > 0) void'(rq.pop_front());
      if (cacc) begin
        for (int i = 0; i < BL; i++) begin
          int k;
          k = int'(caddr >> 2) + i;
          if (cinstr == CMD_WRITE)
            mem[k] = (wq.size() > 0) ? wq.pop_front() : 32'hBAD0_0000;
          else
            rq.push_back(mem.exists(k) ? mem[k] : 32'hDEAD_BEEF);
        end
      end
      ib_data     = PIX0 + 32'(ib_idx);
      p0_rd_data  = (rq.size() > 0) ? rq[0] : 32'h0;
      p0_rd_empty = (rq.size() == 0) || (cyc % 4 == 1);
      p0_wr_full  = (cyc % 5 == 3);
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  int          ob_seen = 0, last_ob_cyc = -10;
  int          wr_acc = 0, last_wr_acc_cyc = -10;
  int          fw_cnt = 0, fr_cnt = 0;
  bit          in_cmd = 0;
  int          hold_cnt = 0;
  logic [29:0] held_addr;

  always @(negedge clk) begin
    if (!reset) begin
      if (ob_we) begin
        ob_seen++;
        last_ob_cyc = cyc;
        if (exp_ob.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ob_unexpected actual=%0h expected=none", ob_data);
        end else begin
          check("ob_data", ob_data, exp_ob.pop_front());
        end
      end
      if (p0_wr_en) check("wr_mask", p0_wr_mask, 4'b0000);
      if (p0_cmd_en) begin
        if (!in_cmd) begin
          in_cmd    = 1;
          hold_cnt  = 0;
          held_addr = p0_cmd_byte_addr;
        end else begin
          check("cmd_addr_hold", p0_cmd_byte_addr, held_addr);
        end
        hold_cnt++;
        if (!p0_cmd_full) begin
          in_cmd = 0;
          if (exp_cmd.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected actual=instr%0d@%0h expected=none",
                     p0_cmd_instr, p0_cmd_byte_addr);
          end else begin
            cmd_t e;
            e = exp_cmd.pop_front();
            check("cmd_instr", p0_cmd_instr, e.instr);
            check("cmd_addr", p0_cmd_byte_addr, e.addr);
            check("cmd_bl", p0_cmd_bl, 6'(BL - 1));
            check("cmd_hold", hold_cnt, e.hold);
          end
          if (p0_cmd_instr == CMD_WRITE) begin
            wr_acc++;
            last_wr_acc_cyc = cyc;
          end
        end
      end
      if (frame_written) begin
        fw_cnt++;
        check("frame_written_lat", cyc - last_wr_acc_cyc, 1);
        check("frame_written_burst", wr_acc % (FW / BL), 0);
      end
      if (frame_read) begin
        fr_cnt++;
        check("frame_read_lat", cyc - last_ob_cyc, 1);
        check("frame_read_words", ob_seen % FW, 0);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed stimulus ----------------
  initial begin
    int n;
    reset       = 1'b1;
    calib_done  = 1'b0;
    frame_start = 1'b0;
    ib_count    = '0;
    ob_count    = '0;
    p0_cmd_full = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_en", p0_cmd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", p0_cmd_instr, 0);
    check("rst_addr", p0_cmd_byte_addr, 0);
    check("rst_bl", p0_cmd_bl, 6'(BL - 1));
    check("rst_ib_re", ib_re, 0);
    check("rst_ob_we", ob_we, 0);
    check("rst_pulses", {frame_written, frame_read}, 0);

    // Data available but MCB not calibrated: nothing may be granted.
    tick();
    ib_count = 24'd32;
    ob_count = 11'd1000;
    repeat (20) tick();
    check("calib_low_idle", busy, 0);

`ifndef PINGPONG_EN
    // Frame 1: reads starved by a nearly full output FIFO, second write
    // command held off by p0_cmd_full for 5 cycles.
    push_cmd(CMD_WRITE, 30'd0, 1);
    push_cmd(CMD_WRITE, 30'd128, 6);
    calib_done = 1'b1;
    n = 0;
    while (ib_idx < 40 && n < 400) begin tick(); n++; end
    check("wait_second_fill", ib_idx >= 40, 1);
    p0_cmd_full = 1'b1;
    n = 0;
    while (!p0_cmd_en && n < 200) begin tick(); n++; end
    check("wait_held_cmd", p0_cmd_en, 1);
    repeat (5) tick();
    p0_cmd_full = 1'b0;
    n = 0;
    while (fw_cnt < 1 && n < 500) begin tick(); n++; end
    check("wait_frame_written_1", fw_cnt, 1);
    repeat (40) tick();
    check("idle_at_frame_end", busy, 0);
    check("writes_done_1", exp_cmd.size(), 0);

    // Open the output FIFO: both read bursts of frame 1.
    push_cmd(CMD_READ, 30'd0, 1);
    push_cmd(CMD_READ, 30'd128, 1);
    ob_count = 11'd0;
    n = 0;
    while (fr_cnt < 1 && n < 1000) begin tick(); n++; end
    check("wait_frame_read_1", fr_cnt, 1);
    check("ob_words_1", ob_seen, 64);
    repeat (30) tick();
    check("no_grant_past_end", busy, 0);

    // Frame 2: rearm, then writes and reads alternate.
    push_cmd(CMD_WRITE, 30'd0, 1);
    push_cmd(CMD_READ, 30'd0, 1);
    push_cmd(CMD_WRITE, 30'd128, 1);
    push_cmd(CMD_READ, 30'd128, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (fr_cnt < 2 && n < 2000) begin tick(); n++; end
    check("wait_frame_read_2", fr_cnt, 2);
    check("ob_words_2", ob_seen, 128);
    check("frames_written", fw_cnt, 2);
`else
    // Fill bank 0 then bank 1 with reads starved; writer must stall.
    push_cmd(CMD_WRITE, 30'd0, 1);
    push_cmd(CMD_WRITE, 30'd128, 1);
    push_cmd(CMD_WRITE, STRIDE, 1);
    push_cmd(CMD_WRITE, STRIDE + 30'd128, 1);
    calib_done = 1'b1;
    n = 0;
    while (fw_cnt < 2 && n < 1000) begin tick(); n++; end
    check("wait_both_banks", fw_cnt, 2);
    repeat (60) tick();
    check("stall_both_full", busy, 0);
    check("stall_words_popped", ib_idx, 128);

    // Drain: bank 0 read frees it, writer resumes into bank 0.
    push_cmd(CMD_READ, 30'd0, 1);
    push_cmd(CMD_READ, 30'd128, 1);
    push_cmd(CMD_WRITE, 30'd0, 1);
    push_cmd(CMD_READ, STRIDE, 1);
    push_cmd(CMD_WRITE, 30'd128, 1);
    push_cmd(CMD_READ, STRIDE + 30'd128, 1);
    push_cmd(CMD_READ, 30'd0, 1);
    push_cmd(CMD_READ, 30'd128, 1);
    ob_count = 11'd0;
    n = 0;
    while (ib_idx < 192 && n < 3000) begin tick(); n++; end
    check("wait_resume_writes", ib_idx >= 192, 1);
    ib_count = 24'd0;
    n = 0;
    while (fr_cnt < 3 && n < 3000) begin tick(); n++; end
    check("wait_frame_read_3", fr_cnt, 3);
    repeat (30) tick();
    check("ob_words_pp", ob_seen, 192);
    check("frames_written_pp", fw_cnt, 3);
`endif

    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("ob_queue_empty", exp_ob.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
